// File: rtl/shiftadd_multiplier.sv
// Sequential unsigned shift-and-add multiplier: WIDTH RUN cycles per product,
// one-cycle done pulse, registered product held until the next result.

module ripple_carry_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    logic [WIDTH-1:0] carry;

    // The carry out of the top bit is never needed, so the chain stops one bit short.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end
endmodule

module shiftadd_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   out_q, out_d;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;
    logic            accept;
    logic            count_last;

    assign addend     = mplier_q[0] ? mcand_q : '0;
    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign count_last = (count_q == CW'(WIDTH - 1));

    ripple_carry_adder #(.WIDTH(PW)) u_adder (
        .a_i   (acc_q),
        .b_i   (addend),
        .sum_o (sum)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        out_d    = out_q;

        if (accept) begin
            state_d  = RUN;
            mcand_d  = {{WIDTH{1'b0}}, input1};
            mplier_d = input2;
            acc_d    = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_last) begin
                        state_d = DONE;
                        out_d   = sum;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
endmodule

// File: doc/shiftadd_multiplier.md
SHIFTADD_MULTIPLIER -- requirements
Module: shiftadd_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on rising edge of clk.
REQ-005 input1  input  WIDTH  unsigned multiplicand, captured when start is accepted.
REQ-006 input2  input  WIDTH  unsigned multiplier, captured when start is accepted.
REQ-007 out  output  2*WIDTH  unsigned product, registered.
REQ-008 busy  output  1  high while a multiply is in progress.
REQ-009 done  output  1  one-cycle pulse marking that out holds a new product.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-011 Start acceptance: start high in IDLE or DONE SHALL be accepted on that edge.
REQ-012 Start ignored: start high in RUN SHALL be ignored, with no effect on operands, count or out.
REQ-013 On acceptance the block SHALL capture input1/input2 into internal registers, clear the accumulator and step counter, and enter RUN.
REQ-014 Each RUN cycle: if the multiplier LSB is 1, the accumulator SHALL add the multiplicand (zero-extended to 2*WIDTH); the multiplicand SHALL shift left 1, the multiplier SHALL shift right 1, and the counter SHALL increment.
REQ-015 Additions SHALL be 2*WIDTH-bit unsigned, using the team's ripple-carry adder.
REQ-016 The accumulator cannot overflow, since the product of two WIDTH-bit values fits in 2*WIDTH bits, so no carry-out is kept.
REQ-017 RUN SHALL last exactly WIDTH cycles regardless of operand values, with no early termination on zero multiplier.
REQ-018 After the WIDTH-th RUN edge the FSM SHALL enter DONE and load out with the accumulator value.
REQ-019 done SHALL be high for exactly the one cycle spent in DONE.
REQ-020 Latency: start accepted at edge k SHALL give done high and out valid in the cycle after edge k+WIDTH (WIDTH+1 cycles total).
REQ-021 busy SHALL be high exactly while in RUN.
REQ-022 DONE SHALL return to IDLE on the next edge unless start is high, in which case REQ-013 applies (back-to-back operation, no idle gap).
REQ-023 out SHALL hold its last product through IDLE and RUN until the next DONE; it SHALL NOT show partial sums.
REQ-024 Operand inputs SHALL be don't-care except on the accepting edge; changes during RUN SHALL NOT affect the result.

Reset
REQ-025 On reset high at a rising edge: state=IDLE, out=0, busy=0, done=0, accumulator, counter and operand registers cleared.
REQ-026 Reset SHALL take priority over start and over any in-progress multiply, which is discarded with no done pulse.
REQ-027 Start held high together with reset SHALL NOT be accepted; it is accepted on the first edge with reset low.

Verification
REQ-028 Basic multiply: reset, then input1=13, input2=11, start for 1 cycle -> busy for 8 cycles, then done=1 for one cycle with out=143, then IDLE with out held at 143.
REQ-029 Extremes: 255*255 -> out=65025; 0*200 -> out=0 after the full 8 RUN cycles; 1*255 -> out=255.
REQ-030 Start while busy: start with input1=6, input2=7, then start again at RUN cycle 3 with input1=9, input2=9 -> out=42, single done pulse at the original time.
REQ-031 Operand change in RUN: start 20*5, then change input1/input2 to 0 during RUN -> out=100.
REQ-032 Reset mid-operation: start 100*3, assert reset at RUN cycle 4 -> out=0, busy=0, no done pulse; then start 4*4 -> out=16 after WIDTH+1 cycles.
REQ-033 Back-to-back: start held high across DONE (12*12, then 3*5) -> done pulses 9 cycles apart, out=144 then out=15, busy low only during the DONE cycles.
